mem_port_arbiter: RTL and testbench

- Shares the single-ported unified instruction/data memory between the fetch stage and the load/store path.
- Grants one access at a time and sequences it through a fixed-latency memory.
- Generates byte enables from the access size, and aligns and extends load data.
- Drives a stall to the pipeline while any request is pending or in flight.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_lane_align.sv | 26 ++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: access size and arbiter state encodings plus alignment helpers
package mem_port_arbiter_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_CAPTURE,
        ARB_RESP
    } arb_state_e;

    function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
        return size == SIZE_BYTE ? lo : size == SIZE_HALF ? {lo[1], 1'b0} : 2'b00;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return size == SIZE_BYTE ? 1'b0 : size == SIZE_HALF ? lo[0] : |lo;
    endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-enable generation, store lane replication, load lane extraction/extension
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // reserved size 11 falls through to the word case everywhere
    always_comb begin
        be        = size == SIZE_BYTE ? 4'b0001 << lo : size == SIZE_HALF ? (lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_rep = size == SIZE_BYTE ? {4{wdata[7:0]}} : size == SIZE_HALF ? {2{wdata[15:0]}} : wdata;
        rbyte     = rdata[{lo, 3'b000} +: 8];
        rhalf     = lo[1] ? rdata[31:16] : rdata[15:0];
        rdata_ext = size == SIZE_BYTE ? {{24{~uns & rbyte[7]}}, rbyte} :
                    size == SIZE_HALF ? {{16{~uns & rhalf[15]}}, rhalf} : rdata;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch vs load/store arbiter for one fixed-latency memory port (option: MISALIGN_TRAP_EN)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [31:0]       d_rdata,
`ifdef MISALIGN_TRAP_EN
    output logic              d_misalign,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              stall
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int CW = MEM_LAT > 2 ? $clog2(MEM_LAT - 1) : 1;

    arb_state_e        state_q, state_d;
    logic [SW-1:0]     starve_q;
    logic [CW-1:0]     wcnt_q;
    logic              cmd_d, cmd_we, cmd_uns, cmd_mis;
    logic [1:0]        cmd_size, cmd_lo;
    logic [ADDR_W-3:0] cmd_addr;
    logic [31:0]       cmd_wdata, rdata_q;
    logic [3:0]        be;
    logic [31:0]       wrep, rext;
    logic              arb, f_win, issue, resp, trap;
    logic              unused_ok;

    assign unused_ok = ^if_addr[1:0];

`ifdef MISALIGN_TRAP_EN
    assign trap       = d_gnt & misaligned(d_size, d_addr[1:0]);
    assign d_misalign = d_valid & cmd_mis;
`else
    assign trap = 1'b0;
`endif

    mem_lane_align u_align (
        .size      (cmd_size),
        .uns       (cmd_uns),
        .lo        (cmd_lo),
        .wdata     (cmd_wdata),
        .rdata     (rdata_q),
        .be        (be),
        .wdata_rep (wrep),
        .rdata_ext (rext)
    );

    // arbitration and output decode; data wins unless fetch has been starved STARVE_MAX times
    always_comb begin
        arb       = state_q == ARB_IDLE || state_q == ARB_RESP;
        f_win     = if_req & (~d_req | starve_q == SW'(STARVE_MAX));
        if_gnt    = arb & ~rst & f_win;
        d_gnt     = arb & ~rst & d_req & ~f_win;
        issue     = state_q == ARB_ISSUE;
        resp      = state_q == ARB_RESP;
        mem_en    = issue;
        mem_we    = issue & cmd_we;
        mem_addr  = issue ? cmd_addr : '0;
        mem_be    = issue ? be : 4'b0000;
        mem_wdata = issue ? wrep : 32'h0;
        if_valid  = resp & ~cmd_d;
        if_rdata  = if_valid ? rdata_q : 32'h0;
        d_valid   = resp & cmd_d;
        d_rdata   = d_valid & ~cmd_we & ~cmd_mis ? rext : 32'h0;
        stall     = (if_req & ~if_gnt) | (d_req & ~d_gnt) | ~arb;
    end

    // next-state logic; a trapped misaligned access skips the memory entirely
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE, ARB_RESP: state_d = (if_gnt | d_gnt) ? (trap ? ARB_RESP : ARB_ISSUE) : ARB_IDLE;
            ARB_ISSUE:          state_d = cmd_we ? ARB_RESP : MEM_LAT == 1 ? ARB_CAPTURE : ARB_WAIT;
            ARB_WAIT:           state_d = wcnt_q == CW'(MEM_LAT - 2) ? ARB_CAPTURE : ARB_WAIT;
            ARB_CAPTURE:        state_d = ARB_RESP;
            default:            state_d = ARB_IDLE;
        endcase
    end

    // state, starve counter, latency counter, command latch on grant, read capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            starve_q  <= '0;
            wcnt_q    <= '0;
            cmd_d     <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_uns   <= 1'b0;
            cmd_mis   <= 1'b0;
            cmd_size  <= 2'b00;
            cmd_lo    <= 2'b00;
            cmd_addr  <= '0;
            cmd_wdata <= 32'h0;
            rdata_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            if (if_gnt) begin
                starve_q <= '0;
            end else if (d_gnt & if_req) begin
                starve_q <= starve_q + 1'b1;
            end
            wcnt_q <= state_q == ARB_WAIT ? wcnt_q + 1'b1 : '0;
            if (if_gnt | d_gnt) begin
                cmd_d     <= d_gnt;
                cmd_we    <= d_gnt & d_we;
                cmd_uns   <= d_unsigned;
                cmd_mis   <= trap;
                cmd_size  <= d_gnt ? d_size : SIZE_WORD;
                cmd_lo    <= d_gnt ? align_lo(d_size, d_addr[1:0]) : 2'b00;
                cmd_addr  <= d_gnt ? d_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
                cmd_wdata <= d_wdata;
            end
            if (state_q == ARB_CAPTURE) begin
                rdata_q <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with MEM_LAT=2, STARVE_MAX=4
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    typedef struct packed {logic is_d; logic [31:0] data;} exp_t;
    typedef struct packed {logic [1:0] sz; logic [31:0] addr; logic [31:0] wd; logic [3:0] be; logic [31:0] wr; logic [29:0] ma;} st_t;
    typedef struct packed {logic [1:0] sz; logic uns; logic [31:0] addr; logic [31:0] ex;} ld_t;

    logic        clk = 0, rst = 1;
    logic        if_req = 0, d_req = 0, d_we = 0, d_unsigned = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic [1:0]  d_size = 0;
    logic        if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, stall;
    logic [31:0] if_rdata, d_rdata, mem_wdata;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
`ifdef MISALIGN_TRAP_EN
    logic        d_misalign;
`endif

    exp_t q[$];
    exp_t e;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
`ifdef MISALIGN_TRAP_EN
        .d_misalign(d_misalign),
`endif
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall)
    );

    task automatic test_reset;
        rst = 1;
        repeat (2) @(negedge clk);
        #1 total++;
        if ({if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_we, stall, mem_addr, mem_be, mem_wdata, if_rdata, d_rdata} !== '0)
            $display("FAIL reset_outs got %h want 0", {if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_we, stall, mem_addr, mem_be, mem_wdata, if_rdata, d_rdata});
        else passed++;
        rst = 0;
    endtask

    task automatic test_fetch;
        bit seen = 0;
        @(negedge clk);
        if_req = 1; if_addr = 32'h10; mem_rdata = 32'h00500093;
        #1 total++;
        if (if_gnt !== 1'b1 || d_gnt !== 1'b0) $display("FAIL fetch_gnt got if_gnt=%b d_gnt=%b want 1/0", if_gnt, d_gnt);
        else passed++;
        q.push_back({1'b0, 32'h00500093});
        @(negedge clk);
        if_req = 0; if_addr = 32'hFFC;
        #1 total++;
        if ({mem_en, mem_we, mem_addr, mem_be} !== {1'b1, 1'b0, 30'h4, 4'hF})
            $display("FAIL fetch_issue got en=%b we=%b addr=%h be=%b want 1 0 4 1111", mem_en, mem_we, mem_addr, mem_be);
        else passed++;
        @(negedge clk);
        #1 total++;
        if (stall !== 1'b1 || mem_en !== 1'b0) $display("FAIL fetch_wait got stall=%b mem_en=%b want 1/0", stall, mem_en);
        else passed++;
        for (int k = 3; k < 10 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (if_valid) begin
                seen = 1; e = q.pop_front(); total++;
                if (k != 4 || e.is_d || if_rdata !== e.data)
                    $display("FAIL fetch_resp got cycle G+%0d data=%h want G+4 data=%h", k, if_rdata, e.data);
                else passed++;
            end
        end
        if (!seen) begin total++; $display("FAIL fetch_timeout got no if_valid want one"); end
    endtask

    task automatic test_priority;
        bit seen = 0;
        @(negedge clk);
        if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_size = SIZE_WORD; d_addr = 32'h20;
        d_unsigned = 0; mem_rdata = 32'hDEADBEEF;
        #1 total++;
        if (d_gnt !== 1'b1 || if_gnt !== 1'b0) $display("FAIL prio_data_first got d_gnt=%b if_gnt=%b want 1/0", d_gnt, if_gnt);
        else passed++;
        q.push_back({1'b1, 32'hDEADBEEF});
        @(negedge clk);
        d_req = 0;
        #1 total++;
        if ({mem_en, mem_we, mem_addr, mem_be} !== {1'b1, 1'b0, 30'h8, 4'hF})
            $display("FAIL prio_d_issue got en=%b we=%b addr=%h be=%b want 1 0 8 1111", mem_en, mem_we, mem_addr, mem_be);
        else passed++;
        for (int k = 2; k < 10 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (d_valid) begin
                seen = 1; e = q.pop_front(); total++;
                if (k != 4 || !e.is_d || d_rdata !== e.data)
                    $display("FAIL prio_d_resp got cycle G+%0d data=%h want G+4 data=%h", k, d_rdata, e.data);
                else passed++;
                total++;
                if (if_gnt !== 1'b1) $display("FAIL prio_fetch_in_resp got if_gnt=%b want 1", if_gnt);
                else passed++;
                q.push_back({1'b0, 32'hDEADBEEF});
            end
        end
        if (!seen) begin total++; $display("FAIL prio_timeout got no d_valid want one"); end
        @(negedge clk);
        if_req = 0;
        #1 total++;
        if (mem_en !== 1'b1 || mem_addr !== 30'h10) $display("FAIL prio_f_issue got en=%b addr=%h want 1 10", mem_en, mem_addr);
        else passed++;
        seen = 0;
        for (int k = 2; k < 10 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (if_valid) begin
                seen = 1; e = q.pop_front(); total++;
                if (k != 4 || e.is_d || if_rdata !== e.data)
                    $display("FAIL prio_f_resp got cycle G+%0d data=%h want G+4 data=%h", k, if_rdata, e.data);
                else passed++;
            end
        end
        if (!seen) begin total++; $display("FAIL prio_f_timeout got no if_valid want one"); end
    endtask

    task automatic test_starve;
        int  ng = 0;
        bit  stop = 0;
        @(negedge clk);
        if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_size = SIZE_WORD; d_addr = 32'h8;
        mem_rdata = 32'h13579BDF;
        for (int c = 0; c < 80 && !(stop && q.size() == 0); c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (stop) begin if_req = 0; d_req = 0; end
            end
            #1;
            if (if_valid | d_valid) begin
                total++;
                if (q.size() == 0) $display("FAIL starve_spurious got valid if=%b d=%b want none", if_valid, d_valid);
                else begin
                    e = q.pop_front();
                    if (e.is_d !== d_valid || if_valid === d_valid || (d_valid ? d_rdata : if_rdata) !== e.data)
                        $display("FAIL starve_resp got if=%b d=%b data=%h want is_d=%b data=%h", if_valid, d_valid, d_valid ? d_rdata : if_rdata, e.is_d, e.data);
                    else passed++;
                end
            end
            if (if_gnt | d_gnt) begin
                ng++; total++;
                if (if_gnt !== (ng == 5) || d_gnt === if_gnt)
                    $display("FAIL starve_order got grant %0d if_gnt=%b d_gnt=%b want if_gnt=%b", ng, if_gnt, d_gnt, ng == 5);
                else passed++;
                q.push_back({d_gnt, 32'h13579BDF});
                if (ng == 6) stop = 1;
            end
        end
        if (!(stop && q.size() == 0)) begin total++; $display("FAIL starve_timeout got %0d grants %0d pending want 6/0", ng, q.size()); end
    endtask

    task automatic test_store;
        st_t t[6];
        int  n = 4;
        t[0] = {SIZE_BYTE, 32'h103, 32'h000000AB, 4'b1000, 32'hABABABAB, 30'h40};
        t[1] = {SIZE_HALF, 32'h102, 32'h00001234, 4'b1100, 32'h12341234, 30'h40};
        t[2] = {SIZE_WORD, 32'h104, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 30'h41};
        t[3] = {SIZE_BYTE, 32'h200, 32'hFFFFFF5A, 4'b0001, 32'h5A5A5A5A, 30'h80};
`ifndef MISALIGN_TRAP_EN
        t[4] = {SIZE_HALF, 32'h101, 32'h0000BEEF, 4'b0011, 32'hBEEFBEEF, 30'h40};
        t[5] = {SIZE_WORD, 32'h106, 32'h01020304, 4'b1111, 32'h01020304, 30'h41};
        n = 6;
`endif
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            d_req = 1; d_we = 1; d_size = t[i].sz; d_addr = t[i].addr; d_wdata = t[i].wd;
            #1 total++;
            if (d_gnt !== 1'b1) $display("FAIL store_gnt[%0d] got %b want 1", i, d_gnt);
            else passed++;
            @(negedge clk);
            d_req = 0; d_we = 0; d_wdata = ~t[i].wd; d_addr = 32'h3; d_size = SIZE_BYTE;
            #1 total++;
            if ({mem_en, mem_we, mem_addr, mem_be, mem_wdata} !== {1'b1, 1'b1, t[i].ma, t[i].be, t[i].wr})
                $display("FAIL store_issue[%0d] got en=%b we=%b addr=%h be=%b wd=%h want 1 1 %h %b %h", i, mem_en, mem_we, mem_addr, mem_be, mem_wdata, t[i].ma, t[i].be, t[i].wr);
            else passed++;
            @(negedge clk);
            #1 total++;
            if (d_valid !== 1'b1 || mem_en !== 1'b0) $display("FAIL store_valid[%0d] got d_valid=%b mem_en=%b want 1/0 at G+2", i, d_valid, mem_en);
            else passed++;
        end
    endtask

    task automatic test_load_ext;
        ld_t t[8];
        t[0] = {SIZE_BYTE, 1'b0, 32'h2, 32'hFFFFFF80};
        t[1] = {SIZE_BYTE, 1'b1, 32'h2, 32'h00000080};
        t[2] = {SIZE_HALF, 1'b0, 32'h2, 32'h00000080};
        t[3] = {SIZE_HALF, 1'b0, 32'h0, 32'hFFFFFF00};
        t[4] = {SIZE_HALF, 1'b1, 32'h0, 32'h0000FF00};
        t[5] = {SIZE_BYTE, 1'b0, 32'h1, 32'hFFFFFFFF};
        t[6] = {SIZE_BYTE, 1'b1, 32'h1, 32'h000000FF};
        t[7] = {SIZE_WORD, 1'b0, 32'h0, 32'h0080FF00};
        mem_rdata = 32'h0080FF00;
        for (int i = 0; i < 8; i++) begin
            bit seen = 0;
            @(negedge clk);
            d_req = 1; d_we = 0; d_size = t[i].sz; d_unsigned = t[i].uns; d_addr = t[i].addr;
            #1 total++;
            if (d_gnt !== 1'b1) $display("FAIL load_gnt[%0d] got %b want 1", i, d_gnt);
            else passed++;
            q.push_back({1'b1, t[i].ex});
            @(negedge clk);
            d_req = 0; d_unsigned = ~t[i].uns; d_addr = 32'h3; d_size = SIZE_WORD;
            for (int k = 2; k < 10 && !seen; k++) begin
                @(negedge clk);
                #1;
                if (d_valid) begin
                    seen = 1; e = q.pop_front(); total++;
                    if (k != 4 || d_rdata !== e.data)
                        $display("FAIL load_ext[%0d] got cycle G+%0d data=%h want G+4 data=%h", i, k, d_rdata, e.data);
                    else passed++;
                end
            end
            if (!seen) begin total++; $display("FAIL load_timeout[%0d] got no d_valid want one", i); end
        end
    endtask

    task automatic test_reset_mid;
        bit seen = 0;
        @(negedge clk);
        d_req = 1; d_we = 0; d_size = SIZE_WORD; d_addr = 32'h30; mem_rdata = 32'h11112222;
        #1 total++;
        if (d_gnt !== 1'b1) $display("FAIL rstmid_gnt got %b want 1", d_gnt);
        else passed++;
        @(negedge clk);
        d_req = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        #1 total++;
        if ({if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_we, stall, mem_addr, mem_be, mem_wdata, if_rdata, d_rdata} !== '0)
            $display("FAIL rstmid_outs got %h want 0", {if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_we, stall, mem_addr, mem_be, mem_wdata, if_rdata, d_rdata});
        else passed++;
        rst = 0;
        repeat (6) begin
            @(negedge clk);
            #1 if (d_valid | if_valid | mem_en) seen = 1;
        end
        total++;
        if (seen) $display("FAIL rstmid_no_valid got activity after reset want none");
        else passed++;
        seen = 0;
        @(negedge clk);
        d_req = 1; d_addr = 32'h34; mem_rdata = 32'h55AA55AA;
        #1 total++;
        if (d_gnt !== 1'b1) $display("FAIL rstmid_regnt got %b want 1", d_gnt);
        else passed++;
        q.push_back({1'b1, 32'h55AA55AA});
        @(negedge clk);
        d_req = 0;
        for (int k = 2; k < 10 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (d_valid) begin
                seen = 1; e = q.pop_front(); total++;
                if (k != 4 || d_rdata !== e.data)
                    $display("FAIL rstmid_resp got cycle G+%0d data=%h want G+4 data=%h", k, d_rdata, e.data);
                else passed++;
            end
        end
        if (!seen) begin total++; $display("FAIL rstmid_timeout got no d_valid want one"); end
    endtask

`ifdef MISALIGN_TRAP_EN
    task automatic test_misalign;
        @(negedge clk);
        d_req = 1; d_we = 0; d_size = SIZE_WORD; d_addr = 32'h6; mem_rdata = 32'h99999999;
        #1 total++;
        if (d_gnt !== 1'b1) $display("FAIL mis_gnt got %b want 1", d_gnt);
        else passed++;
        q.push_back({1'b1, 32'h0});
        @(negedge clk);
        d_req = 0;
        #1 total++;
        e = q.pop_front();
        if (mem_en !== 1'b0 || d_valid !== 1'b1 || d_misalign !== 1'b1 || d_rdata !== e.data)
            $display("FAIL mis_resp got en=%b valid=%b mis=%b data=%h want 0 1 1 %h", mem_en, d_valid, d_misalign, d_rdata, e.data);
        else passed++;
        @(negedge clk);
        #1 total++;
        if (mem_en !== 1'b0 || d_valid !== 1'b0 || d_misalign !== 1'b0)
            $display("FAIL mis_after got en=%b valid=%b mis=%b want 0 0 0", mem_en, d_valid, d_misalign);
        else passed++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_starve();
        test_store();
        test_load_ext();
        test_reset_mid();
`ifdef MISALIGN_TRAP_EN
        test_misalign();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
